// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button inputs and conditioned level/pulse/direction outputs
interface btn_conditioner_if #(parameter int N_CH = 5);
  logic [N_CH-1:0] btn_in_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] stroke_o;
  logic [1:0] dir_o;
  logic dir_valid_o;
  modport slave (input btn_in_i, output level_o, press_o, release_o, stroke_o, dir_o, dir_valid_o);
  modport master (output btn_in_i, input level_o, press_o, release_o, stroke_o, dir_o, dir_valid_o);
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel sync, debounce, edge pulses, auto-repeat and last-direction tracking
module btn_conditioner #(
  parameter int N_CH = 5,
  parameter int DB_CYCLES = 500000,
  parameter int REP_DELAY = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input logic clk,
  input logic reset,
  btn_conditioner_if.slave bus
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int HMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int HW = $clog2(HMAX + 1);
  logic [N_CH-1:0] s1_q, s2_q, level_q, level_d, press_q, press_d, rel_q, rel_d;
  logic [N_CH-1:0] stroke_q, stroke_d, rep_q, rep_d;
  logic [DW-1:0] db_q [N_CH];
  logic [DW-1:0] db_d [N_CH];
  logic [HW-1:0] hold_q [N_CH];
  logic [HW-1:0] hold_d [N_CH];
  logic [1:0] dir_q, dir_d;
  logic dv_q, dv_d;
  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d = '0;
    stroke_d = '0;
    rep_d = '0;
    dir_d = dir_q;
    dv_d = dv_q;
    for (int i = 0; i < N_CH; i++) begin
      db_d[i] = '0;
      hold_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (db_q[i] == DW'(DB_CYCLES - 1)) level_d[i] = s2_q[i];
        else db_d[i] = db_q[i] + 1'b1;
      end
      press_d[i] = level_d[i] & ~level_q[i];
      rel_d[i] = level_q[i] & ~level_d[i];
      stroke_d[i] = press_d[i];
      // rep_q selects between the initial delay and the steady repeat period
      if (REP_DELAY != 0 && level_d[i] && !press_d[i]) begin
        rep_d[i] = rep_q[i];
        hold_d[i] = hold_q[i] + 1'b1;
        if (hold_q[i] == (rep_q[i] ? HW'(REP_PERIOD - 1) : HW'(REP_DELAY - 1))) begin
          stroke_d[i] = 1'b1;
          hold_d[i] = '0;
          rep_d[i] = 1'b1;
        end
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (press_q[i]) begin
        dir_d = 2'(i);
        dv_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q <= '0;
      stroke_q <= '0;
      rep_q <= '0;
      db_q <= '{default: '0};
      hold_q <= '{default: '0};
      dir_q <= '0;
      dv_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_in_i;
      s2_q <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
      stroke_q <= stroke_d;
      rep_q <= rep_d;
      db_q <= db_d;
      hold_q <= hold_d;
      dir_q <= dir_d;
      dv_q <= dv_d;
    end
  end
  assign bus.level_o = level_q;
  assign bus.press_o = press_q;
  assign bus.release_o = rel_q;
  assign bus.stroke_o = stroke_q;
  assign bus.dir_o = dir_q;
  assign bus.dir_valid_o = dv_q;
endmodule
